// File: rtl/pipe_stage_skid.sv
// Bundled pipeline-stage register: data + control, valid/ready handshake, 2-entry skid buffer.
// Define PIPE_STATS_EN to add saturating stall/bubble counters (stall_cnt, bubble_cnt).
module pipe_stage_skid #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 12
`ifdef PIPE_STATS_EN
   ,
   parameter int unsigned CNT_W  = 16
`endif
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic              enable,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy
`ifdef PIPE_STATS_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   typedef enum logic [1:0] {StEmpty = 2'd0, StOne = 2'd1, StTwo = 2'd2} occ_e;

   occ_e              occ_q, occ_d;
   logic              in_ready_q, in_ready_d;
   logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
   logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
   logic              held_valid;
   logic              accept, emit;

   assign held_valid = (occ_q != StEmpty);
   assign in_ready   = enable & in_ready_q;
   assign out_valid  = enable & held_valid;
   assign accept     = in_valid & in_ready;
   assign emit       = out_valid & out_ready;

   assign occupancy  = occ_q;
   assign out_data   = main_data_q;
   // Masked on held state so a frozen stage keeps presenting its control bundle.
   assign out_ctrl   = held_valid ? main_ctrl_q : {CTRL_W{1'b0}};

   always_comb begin
      occ_d       = occ_q;
      main_data_d = main_data_q;
      main_ctrl_d = main_ctrl_q;
      skid_data_d = skid_data_q;
      skid_ctrl_d = skid_ctrl_q;
      if (enable) begin
         if (flush) begin
            occ_d = StEmpty;
         end else begin
            unique case (occ_q)
               StEmpty: begin
                  if (accept) begin
                     main_data_d = in_data;
                     main_ctrl_d = in_ctrl;
                     occ_d       = StOne;
                  end
               end
               StOne: begin
                  if (accept && emit) begin
                     main_data_d = in_data;
                     main_ctrl_d = in_ctrl;
                  end else if (accept) begin
                     skid_data_d = in_data;
                     skid_ctrl_d = in_ctrl;
                     occ_d       = StTwo;
                  end else if (emit) begin
                     occ_d = StEmpty;
                  end
               end
               StTwo: begin
                  if (emit) begin
                     main_data_d = skid_data_q;
                     main_ctrl_d = skid_ctrl_q;
                     occ_d       = StOne;
                  end
               end
               default: occ_d = StEmpty;
            endcase
         end
      end
      in_ready_d = (occ_d != StTwo);
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         occ_q       <= StEmpty;
         in_ready_q  <= 1'b1;
         main_data_q <= '0;
         main_ctrl_q <= '0;
         skid_data_q <= '0;
         skid_ctrl_q <= '0;
      end else begin
         occ_q       <= occ_d;
         in_ready_q  <= in_ready_d;
         main_data_q <= main_data_d;
         main_ctrl_q <= main_ctrl_d;
         skid_data_q <= skid_data_d;
         skid_ctrl_q <= skid_ctrl_d;
      end
   end

`ifdef PIPE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, bubble_cnt_q, bubble_cnt_d;

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (enable && flush) begin
         stall_cnt_d  = '0;
         bubble_cnt_d = '0;
      end else if (enable) begin
         if (out_valid && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
         if (!out_valid && out_ready && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!arst_n) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed self-checking bench for pipe_stage_skid; stats checks build only with PIPE_STATS_EN.
module tb_pipe_stage_skid;

   logic        clk = 1'b0;
   logic        arst_n, enable, flush, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] in_data, out_data;
   logic [11:0] in_ctrl, out_ctrl;
   logic [1:0]  occupancy;
`ifdef PIPE_STATS_EN
   logic [15:0] stall_cnt, bubble_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   pipe_stage_skid dut (
      .clk       (clk),
      .arst_n    (arst_n),
      .enable    (enable),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_ctrl   (in_ctrl),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ctrl  (out_ctrl),
      .occupancy (occupancy)
`ifdef PIPE_STATS_EN
      ,
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
`endif
   );

   function automatic logic [11:0] ctrl_of(input logic [31:0] d);
      return ~d[11:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic v, input logic [31:0] d);
      in_valid = v;
      in_data  = d;
      in_ctrl  = ctrl_of(d);
   endtask

   initial begin
      arst_n = 1'b0; enable = 1'b1; flush = 1'b0; out_ready = 1'b0;
      offer(1'b0, 32'h0);
      tick();
      check("rst_occ", 32'(occupancy), 0);
      check("rst_oval", 32'(out_valid), 0);
      check("rst_irdy", 32'(in_ready), 1);
      check("rst_data", out_data, 0);
      check("rst_ctrl", 32'(out_ctrl), 0);

      // 1 streaming
      arst_n = 1'b1; out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         offer(1'b1, 32'(i));
         tick();
         check("strm_data", out_data, 32'(i));
         check("strm_ctrl", 32'(out_ctrl), 32'(ctrl_of(32'(i))));
         check("strm_occ", 32'(occupancy), 1);
         check("strm_irdy", 32'(in_ready), 1);
      end
      offer(1'b0, 32'h0);
      tick();
      check("strm_drain", 32'(occupancy), 0);
      check("strm_oval0", 32'(out_valid), 0);
      check("strm_ctrl0", 32'(out_ctrl), 0);

      // 2 backpressure
      out_ready = 1'b0;
      offer(1'b1, 32'hA);
      tick();
      check("bp_a_data", out_data, 32'hA);
      check("bp_a_occ", 32'(occupancy), 1);
      offer(1'b1, 32'hB);
      tick();
      check("bp_b_occ", 32'(occupancy), 2);
      check("bp_b_irdy", 32'(in_ready), 0);
      check("bp_b_hold", out_data, 32'hA);
      offer(1'b1, 32'hC);
      tick();
      check("bp_c_occ", 32'(occupancy), 2);
      check("bp_c_hold", out_data, 32'hA);
      check("bp_c_ctrl", 32'(out_ctrl), 32'(ctrl_of(32'hA)));
      out_ready = 1'b1;
      tick();
      check("bp_out_b", out_data, 32'hB);
      check("bp_out_b_occ", 32'(occupancy), 1);
      check("bp_out_b_irdy", 32'(in_ready), 1);
      tick();
      check("bp_out_c", out_data, 32'hC);
      check("bp_out_c_occ", 32'(occupancy), 1);
      offer(1'b0, 32'h0);
      tick();
      check("bp_empty", 32'(occupancy), 0);

      // 3 flush at occupancy 2
      out_ready = 1'b0;
      offer(1'b1, 32'h11);
      tick();
      offer(1'b1, 32'h22);
      tick();
      check("fl_pre_occ", 32'(occupancy), 2);
      flush = 1'b1;
      offer(1'b1, 32'h55);
      tick();
      check("fl_occ", 32'(occupancy), 0);
      check("fl_oval", 32'(out_valid), 0);
      check("fl_ctrl", 32'(out_ctrl), 0);
      check("fl_irdy", 32'(in_ready), 1);
      flush = 1'b0; out_ready = 1'b1;
      offer(1'b0, 32'h0);
      tick();
      tick();
      check("fl_no55", 32'(out_valid), 0);

      // 4 freeze at occupancy 1
      out_ready = 1'b0;
      offer(1'b1, 32'h77);
      tick();
      offer(1'b0, 32'h0);
      enable = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid  = i[0];
         out_ready = i[1];
         flush     = i[0] ^ i[1];
         in_data   = 32'h99;
         in_ctrl   = ctrl_of(32'h99);
         #1;
         check("frz_oval", 32'(out_valid), 0);
         check("frz_irdy", 32'(in_ready), 0);
         tick();
         check("frz_occ", 32'(occupancy), 1);
         check("frz_data", out_data, 32'h77);
         check("frz_ctrl", 32'(out_ctrl), 32'(ctrl_of(32'h77)));
      end
      flush = 1'b0; out_ready = 1'b0;
      offer(1'b0, 32'h0);
      enable = 1'b1;
      #1;
      check("frz_restore", 32'(out_valid), 1);

      // 5 synchronous reset at occupancy 2
      offer(1'b1, 32'h88);
      tick();
      offer(1'b0, 32'h0);
      check("sr_pre_occ", 32'(occupancy), 2);
      arst_n = 1'b0;
      #2;
      check("sr_hold_occ", 32'(occupancy), 2);
      check("sr_hold_data", out_data, 32'h77);
      tick();
      check("sr_occ", 32'(occupancy), 0);
      check("sr_oval", 32'(out_valid), 0);
      check("sr_irdy", 32'(in_ready), 1);
      check("sr_data", out_data, 0);
      check("sr_ctrl", 32'(out_ctrl), 0);
      arst_n = 1'b1;

`ifdef PIPE_STATS_EN
      // 6 stall counter saturation and flush clear
      check("st_rst", 32'(stall_cnt), 0);
      out_ready = 1'b0;
      offer(1'b1, 32'h99);
      tick();
      offer(1'b0, 32'h0);
      repeat (70000) tick();
      check("st_sat", 32'(stall_cnt), 32'hFFFF);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("st_clr", 32'(stall_cnt), 0);
      check("bb_clr", 32'(bubble_cnt), 0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
